// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares port 0 of the 256x32 data SRAM between the Ibex data
// interface and the eFPGA fabric data interface. Grants are combinational, and
// the granted request drives the SRAM in the same cycle. The response (rvalid,
// err, rdata) is returned one cycle later to the port that owned the access.
// Byte addresses with addr[11:10] != 0 are granted but never reach the SRAM;
// they are answered with err=1.
// Optional build macro: DMEM_ARB_ROUND_ROBIN_EN selects round-robin on
// contention. When it is undefined, the core has fixed priority.
module dmem_arbiter (
  input  logic        clk,
  input  logic        resetn,

  input  logic        core_req_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [11:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,

  input  logic        fab_req_i,
  output logic        fab_gnt_o,
  output logic        fab_rvalid_o,
  input  logic        fab_we_i,
  input  logic [3:0]  fab_be_i,
  input  logic [11:0] fab_addr_i,
  input  logic [31:0] fab_wdata_i,
  output logic [31:0] fab_rdata_o,
  output logic        fab_err_o,

  output logic        sram_csb0_o,
  output logic        sram_web0_o,
  output logic [3:0]  sram_wmask0_o,
  output logic [7:0]  sram_addr0_o,
  output logic [31:0] sram_din0_o,
  input  logic [31:0] sram_dout0_i
);

  logic        core_win, fab_win;
  logic        any_gnt;
  logic        req_we;
  logic [3:0]  req_be;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        out_of_range;
  logic        sram_access;
  logic        rd_ok;

  logic [1:0]  rv_d, rv_q;
  logic        err_d, err_q;
  logic        rd_d, rd_q;
  logic        own_d, own_q;

  // Sub-word accesses use byte enables only, so the byte offset is dropped.
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^{core_addr_i[1:0], fab_addr_i[1:0]};

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last_q: 0 = core was granted most recently, 1 = fabric
  logic last_d, last_q;

  // On contention, the port that was not granted most recently wins.
  always_comb begin
    core_win = core_req_i;
    fab_win  = fab_req_i;
    if (core_req_i && fab_req_i) begin
      core_win = last_q;
      fab_win  = ~last_q;
    end
  end

  // Every grant updates last, whether or not it was contended.
  always_comb begin
    last_d = last_q;
    if (core_gnt_o) begin
      last_d = 1'b0;
    end else if (fab_gnt_o) begin
      last_d = 1'b1;
    end
  end

  // Reset to fabric so the core wins the first contention.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: the fabric is granted only when the core is not requesting.
  always_comb begin
    core_win = core_req_i;
    fab_win  = fab_req_i & ~core_req_i;
  end
`endif

  // Grants are forced low while reset is asserted, independent of the clock.
  assign core_gnt_o = core_win & resetn;
  assign fab_gnt_o  = fab_win & resetn;
  assign any_gnt    = core_gnt_o | fab_gnt_o;

  // Steer the granted requester's fields onto the shared SRAM port.
  always_comb begin
    req_we    = core_we_i;
    req_be    = core_be_i;
    req_addr  = core_addr_i;
    req_wdata = core_wdata_i;
    if (fab_gnt_o) begin
      req_we    = fab_we_i;
      req_be    = fab_be_i;
      req_addr  = fab_addr_i;
      req_wdata = fab_wdata_i;
    end
  end

  assign out_of_range = |req_addr[11:10];
  assign sram_access  = any_gnt & ~out_of_range;

  // Drive the SRAM pins. Pins return to their idle values when no access is in range.
  always_comb begin
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;
    sram_wmask0_o = 4'h0;
    sram_addr0_o  = 8'h00;
    sram_din0_o   = 32'h0;
    if (sram_access) begin
      sram_csb0_o  = 1'b0;
      sram_addr0_o = req_addr[9:2];
      if (req_we) begin
        sram_web0_o   = 1'b0;
        sram_wmask0_o = req_be;
        sram_din0_o   = req_wdata;
      end
    end
  end

  // Capture response attributes in the granting cycle for use one cycle later.
  always_comb begin
    rv_d  = {fab_gnt_o, core_gnt_o};
    err_d = any_gnt & out_of_range;
    rd_d  = any_gnt & ~req_we;
    own_d = fab_gnt_o;
  end

  // Response registers. Reset drops any pending response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv_q  <= 2'b00;
      err_q <= 1'b0;
      rd_q  <= 1'b0;
      own_q <= 1'b0;
    end else begin
      rv_q  <= rv_d;
      err_q <= err_d;
      rd_q  <= rd_d;
      own_q <= own_d;
    end
  end

  assign rd_ok = rd_q & ~err_q;

  // Return the response to its owner only. Writes and errors return zero data.
  always_comb begin
    core_rvalid_o = rv_q[0];
    fab_rvalid_o  = rv_q[1];
    core_err_o    = rv_q[0] & ~own_q & err_q;
    fab_err_o     = rv_q[1] & own_q & err_q;
    core_rdata_o  = 32'h0;
    fab_rdata_o   = 32'h0;
    if (rv_q[0] && !own_q && rd_ok) begin
      core_rdata_o = sram_dout0_i;
    end
    if (rv_q[1] && own_q && rd_ok) begin
      fab_rdata_o = sram_dout0_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: directed stimulus with a response scoreboard for dmem_arbiter.
// It includes a behavioural SRAM model. Build with DMEM_ARB_ROUND_ROBIN_EN to
// expect round-robin contention; without it, expect fixed core priority.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        core_req_i, core_we_i, fab_req_i, fab_we_i;
  logic [3:0]  core_be_i, fab_be_i;
  logic [11:0] core_addr_i, fab_addr_i;
  logic [31:0] core_wdata_i, fab_wdata_i;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic        fab_gnt_o, fab_rvalid_o, fab_err_o;
  logic [31:0] core_rdata_o, fab_rdata_o;
  logic        sram_csb0_o, sram_web0_o;
  logic [3:0]  sram_wmask0_o;
  logic [7:0]  sram_addr0_o;
  logic [31:0] sram_din0_o;
  logic [31:0] sram_dout0_i;

  typedef struct {
    logic        port;   // 0 = core, 1 = fabric
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_we_i(core_we_i), .core_be_i(core_be_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .fab_req_i(fab_req_i), .fab_gnt_o(fab_gnt_o), .fab_rvalid_o(fab_rvalid_o),
    .fab_we_i(fab_we_i), .fab_be_i(fab_be_i), .fab_addr_i(fab_addr_i),
    .fab_wdata_i(fab_wdata_i), .fab_rdata_o(fab_rdata_o), .fab_err_o(fab_err_o),
    .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o), .sram_wmask0_o(sram_wmask0_o),
    .sram_addr0_o(sram_addr0_o), .sram_din0_o(sram_din0_o), .sram_dout0_i(sram_dout0_i)
  );

  // Behavioural model of the 1rw SRAM port 0: masked write, registered read.
  always @(posedge clk) begin
    if (!sram_csb0_o) begin
      if (!sram_web0_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0_o[b]) mem[sram_addr0_o][b*8 +: 8] <= sram_din0_o[b*8 +: 8];
      end else begin
        sram_dout0_i <= mem[sram_addr0_o];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop an expectation for every response and flag missing or extra ones.
  always @(negedge clk) begin
    rsp_t e;
    if (core_rvalid_o || fab_rvalid_o) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid: got core=%0b fab=%0b expected none at %0t",
                 core_rvalid_o, fab_rvalid_o, $time);
      end else begin
        e = sb_q.pop_front();
        check("rsp_owner", {62'b0, core_rvalid_o, fab_rvalid_o}, e.port ? 64'h1 : 64'h2);
        check("rsp_err", {62'b0, core_err_o, fab_err_o}, e.port ? {63'b0, e.err} : {62'b0, e.err, 1'b0});
        check("rsp_rdata", {fab_rdata_o, core_rdata_o},
              e.port ? {e.rdata, 32'h0} : {32'h0, e.rdata});
      end
    end else if (resetn && sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL missing_rvalid: got none expected port %0d at %0t", sb_q[0].port, $time);
      void'(sb_q.pop_front());
    end
  end

  task automatic set_core(input logic req, input logic we, input logic [3:0] be,
                          input logic [11:0] addr, input logic [31:0] wd);
    core_req_i = req; core_we_i = we; core_be_i = be; core_addr_i = addr; core_wdata_i = wd;
  endtask

  task automatic set_fab(input logic req, input logic we, input logic [3:0] be,
                         input logic [11:0] addr, input logic [31:0] wd);
    fab_req_i = req; fab_we_i = we; fab_be_i = be; fab_addr_i = addr; fab_wdata_i = wd;
  endtask

  // Called at posedge+1 with inputs already set. Checks grants at posedge+7, which is
  // after this cycle's negedge, then queues the response expected in the next cycle.
  task automatic step(input logic ecg, input logic efg, input logic ecsb,
                      input logic push, input logic eerr, input logic [31:0] erd);
    rsp_t e;
    #6;
    check("gnt", {62'b0, core_gnt_o, fab_gnt_o}, {62'b0, ecg, efg});
    check("csb", {63'b0, sram_csb0_o}, {63'b0, ecsb});
    if (!ecg && !efg)
      check("idle_pins", {19'b0, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o},
            {19'b0, 1'b1, 44'b0});
    if (push && (ecg || efg)) begin
      e.port = efg; e.err = eerr; e.rdata = erd;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Assert reset with both requests high, check the reset values, then release it.
  task automatic do_reset();
    set_core(1'b1, 1'b0, 4'hF, 12'h010, 32'h0);
    set_fab(1'b1, 1'b0, 4'hF, 12'h020, 32'h0);
    resetn = 1'b0;
    #1;
    check("rst_gnt", {62'b0, core_gnt_o, fab_gnt_o}, 64'h0);
    check("rst_sram", {62'b0, sram_csb0_o, sram_web0_o}, 64'h3);
    check("rst_rsp", {core_rdata_o, fab_rdata_o}, 64'h0);
    check("rst_flags", {60'b0, core_rvalid_o, fab_rvalid_o, core_err_o, fab_err_o}, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    set_core(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
    set_fab(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
    resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    sram_dout0_i = 32'h0;
    @(posedge clk); #1;
    do_reset();
    step(0, 0, 1, 0, 0, 32'h0);

    // Core write then read back.
    set_core(1, 1, 4'hF, 12'h010, 32'hDEADBEEF);
    step(1, 0, 0, 1, 0, 32'h0);
    set_core(1, 0, 4'hF, 12'h010, 32'h0);
    step(1, 0, 0, 1, 0, 32'hDEADBEEF);
    set_core(0, 0, 4'h0, 12'h0, 32'h0);

    // Fabric full write, byte-lane write, and read back.
    set_fab(1, 1, 4'hF, 12'h020, 32'hAABBCCDD);
    step(0, 1, 0, 1, 0, 32'h0);
    set_fab(1, 1, 4'h1, 12'h020, 32'h00000055);
    step(0, 1, 0, 1, 0, 32'h0);
    set_fab(1, 0, 4'hF, 12'h020, 32'h0);
    step(0, 1, 0, 1, 0, 32'hAABBCC55);
    set_fab(0, 0, 4'h0, 12'h0, 32'h0);

    // Out-of-range accesses: granted, SRAM untouched, error response.
    set_core(1, 0, 4'hF, 12'h400, 32'h0);
    step(1, 0, 1, 1, 1, 32'h0);
    set_core(0, 0, 4'h0, 12'h0, 32'h0);
    set_fab(1, 1, 4'hF, 12'h820, 32'h12345678);
    step(0, 1, 1, 1, 1, 32'h0);
    set_fab(0, 0, 4'h0, 12'h0, 32'h0);
    step(0, 0, 1, 0, 0, 32'h0);

    // Contention from reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic c;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      c = (i % 2 == 0);
`else
      c = 1'b1;
`endif
      set_core(1, 0, 4'hF, 12'h010, 32'h0);
      set_fab(1, 0, 4'hF, 12'h020, 32'h0);
      step(c, !c, 0, 1, 0, c ? 32'hDEADBEEF : 32'hAABBCC55);
    end
`ifndef DMEM_ARB_ROUND_ROBIN_EN
    set_core(0, 0, 4'h0, 12'h0, 32'h0);
    step(0, 1, 0, 1, 0, 32'hAABBCC55);
`endif
    set_core(0, 0, 4'h0, 12'h0, 32'h0);
    set_fab(0, 0, 4'h0, 12'h0, 32'h0);
    step(0, 0, 1, 0, 0, 32'h0);

    // Reset during the response cycle of a granted read drops that response.
    set_core(1, 0, 4'hF, 12'h010, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    do_reset();

    // First contention after reset goes to the core.
    set_core(1, 0, 4'hF, 12'h010, 32'h0);
    set_fab(1, 0, 4'hF, 12'h020, 32'h0);
    step(1, 0, 0, 1, 0, 32'hDEADBEEF);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    step(0, 1, 0, 1, 0, 32'hAABBCC55);
`else
    step(1, 0, 0, 1, 0, 32'hDEADBEEF);
`endif
    set_core(0, 0, 4'h0, 12'h0, 32'h0);
    set_fab(0, 0, 4'h0, 12'h0, 32'h0);
    step(0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 32'h0);
    check("sb_drained", 64'(sb_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
